// File: rtl/slice_adder_sequencer.sv
// slice_adder_sequencer
//  Arbitrates two requesters onto one external SLICE_W-bit adder slice and
//  performs a WIDTH-bit addition as NSLICE sequential slice operations,
//  least significant slice first, with the carry registered between slices.
//  The finished result is presented on rsp_* until the consumer accepts it.
module slice_adder_sequencer #(
  parameter int WIDTH   = 12,
  parameter int SLICE_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  // requester 0
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req0_cin,
  // requester 1
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic               req1_cin,
  // result
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_id,
  // external adder slice
  output logic [SLICE_W-1:0] slc_a,
  output logic [SLICE_W-1:0] slc_b,
  output logic               slc_cin,
  input  logic [SLICE_W-1:0] slc_sum,
  input  logic               slc_cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // The operand must split into whole slices; anything else is a build error.
  generate
    if ((WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("slice_adder_sequencer: WIDTH (%0d) must be a multiple of SLICE_W (%0d)",
             WIDTH, SLICE_W);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IDXW-1:0]    idx_reg, idx_next;
  logic               carry_reg, carry_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [WIDTH-1:0]   op_a_reg, op_a_next;
  logic [WIDTH-1:0]   op_b_reg, op_b_next;
  logic               id_reg, id_next;
  logic               last_grant_reg, last_grant_next;

  // Arbitration signals (only meaningful in IDLE).
  logic               any_valid;
  logic               grant_id;
  logic               accept;
  logic               in_idle;
  logic               in_run;
  logic               last_slice;

  // Operand slices, indexed by the current slice position.
  logic [SLICE_W-1:0] a_slice [NSLICE];
  logic [SLICE_W-1:0] b_slice [NSLICE];

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign a_slice[gi] = op_a_reg[gi*SLICE_W +: SLICE_W];
    assign b_slice[gi] = op_b_reg[gi*SLICE_W +: SLICE_W];
  end

  assign in_idle    = (state_reg == ST_IDLE);
  assign in_run     = (state_reg == ST_RUN);
  assign last_slice = (idx_reg == IDXW'(NSLICE - 1));

  // Round-robin winner: a lone requester wins outright; on contention the
  // requester that was not granted last time wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_reg;
    end else begin
      grant_id = req1_valid;
    end
    // Ready is withheld while reset is asserted, even before the state register reacts.
    accept     = in_idle & rst_n & any_valid;
    req0_ready = accept & ~grant_id;
    req1_ready = accept &  grant_id;
  end

  // Slice drive: operands and carry for the current slice during RUN, zero otherwise.
  always_comb begin
    slc_a   = '0;
    slc_b   = '0;
    slc_cin = 1'b0;
    if (in_run) begin
      slc_a   = a_slice[idx_reg];
      slc_b   = b_slice[idx_reg];
      slc_cin = carry_reg;
    end
  end

  // Response outputs are only non-zero while the result is being offered.
  always_comb begin
    rsp_valid = (state_reg == ST_RESP);
    rsp_sum   = rsp_valid ? result_reg : '0;
    rsp_cout  = rsp_valid & carry_reg;
    rsp_id    = rsp_valid & id_reg;
  end

  // Next-state and datapath update for the IDLE -> RUN -> RESP sequence.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    carry_next      = carry_reg;
    result_next     = result_reg;
    op_a_next       = op_a_reg;
    op_b_next       = op_b_reg;
    id_next         = id_reg;
    last_grant_next = last_grant_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_a_next       = grant_id ? req1_a   : req0_a;
          op_b_next       = grant_id ? req1_b   : req0_b;
          carry_next      = grant_id ? req1_cin : req0_cin;
          id_next         = grant_id;
          last_grant_next = grant_id;
          idx_next        = '0;
          state_next      = ST_RUN;
        end
      end

      ST_RUN: begin
        // The slice result for this position lands in the matching result field.
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_reg == IDXW'(i)) begin
            result_next[i*SLICE_W +: SLICE_W] = slc_sum;
          end
        end
        carry_next = slc_cout;
        if (last_slice) begin
          idx_next   = '0;
          state_next = ST_RESP;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      carry_reg      <= 1'b0;
      result_reg     <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      carry_reg      <= carry_next;
      result_reg     <= result_next;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      id_reg         <= id_next;
      last_grant_reg <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_slice_adder_sequencer.sv
// Testbench for slice_adder_sequencer: directed scenarios plus a randomized
// two-requester run checked against a transaction-level reference model.
module tb_slice_adder_sequencer;

  localparam int WIDTH   = 12;
  localparam int SLICE_W = 3;
  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int N_RAND  = 3000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic               req0_ready, req1_ready;
  logic [WIDTH-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic               req0_cin = 1'b0, req1_cin = 1'b0;
  logic               rsp_valid, rsp_ready = 1'b0;
  logic [WIDTH-1:0]   rsp_sum;
  logic               rsp_cout, rsp_id;
  logic [SLICE_W-1:0] slc_a, slc_b, slc_sum;
  logic               slc_cin, slc_cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  slice_adder_sequencer #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin), .slc_sum(slc_sum), .slc_cout(slc_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact external slice adder.
  assign {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {{SLICE_W{1'b0}}, slc_cin};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Carry entering each slice, from plain arithmetic on the low operand bits.
  function automatic logic [NSLICE-1:0] carry_seq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic cin);
    longint unsigned m, s;
    logic [NSLICE-1:0] r;
    for (int k = 0; k < NSLICE; k++) begin
      m = (64'd1 << (k * SLICE_W)) - 64'd1;
      s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
      r[k] = s[k * SLICE_W];
    end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check(tag, {rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready, slc_a, slc_b, slc_cin}, 64'd0);
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_a = '0; req1_b = '0; req1_cin = 0; rsp_ready = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    @(negedge clk);
    check_zero(tag);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic wait_grant(input string tag, output int gid);
    int i = 0;
    gid = -1;
    while (gid < 0 && i < 50) begin
      @(negedge clk);
      if (req0_valid && req0_ready) gid = 0;
      else if (req1_valid && req1_ready) gid = 1;
      i++;
    end
    if (gid < 0) check({tag, "_grant_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input string tag, output logic found);
    int i = 0;
    found = 0;
    while (!found && i < 60) begin
      @(negedge clk);
      found = rsp_valid;
      i++;
    end
    if (!found) check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic single_op(input string tag, input int port, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0]    expv;
    logic [NSLICE-1:0] seq;
    int                gid, hs;
    logic              found, early;
    expv = ref_add(a, b, cin);
    rsp_ready = 1;
    if (port == 0) begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1; end
    else begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1; end
    wait_grant(tag, gid);
    check({tag, "_grant"}, 64'(gid), 64'(port));
    hs = cyc;
    @(posedge clk); #1;
    // Operands change after accept and must be ignored.
    req0_valid = 0; req1_valid = 0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b; req0_cin = ~cin; req1_cin = ~cin;
    early = 0;
    for (int k = 0; k < NSLICE; k++) begin
      @(negedge clk);
      seq[k] = slc_cin;
      early  = early | rsp_valid;
    end
    check({tag, "_cin_seq"}, 64'(seq), 64'(carry_seq(a, b, cin)));
    check({tag, "_early_rsp"}, 64'(early), 64'd0);
    wait_rsp(tag, found);
    check({tag, "_latency"}, 64'(cyc - hs), 64'(NSLICE + 1));
    check({tag, "_sum"}, 64'(rsp_sum), 64'(expv[WIDTH-1:0]));
    check({tag, "_cout"}, 64'(rsp_cout), 64'(expv[WIDTH]));
    check({tag, "_id"}, 64'(rsp_id), 64'(port));
  endtask

  typedef struct { logic id; logic [WIDTH:0] val; } exp_t;

  initial begin
    int               gid;
    logic             found;
    logic [WIDTH+1:0] cap;
    logic [WIDTH:0]   e;
    int               nrv;

    // 1/2: single operations and carry propagation.
    clear_inputs();
    do_reset("reset_idle");
    single_op("t1", 0, 12'hFFF, 12'h001, 1'b0);
    single_op("t2a", 0, 12'h7FF, 12'h800, 1'b1);
    single_op("t2b", 1, 12'h000, 12'h000, 1'b1);

    // 3: round robin with both requesters held valid from reset.
    clear_inputs();
    req0_valid = 1; req1_valid = 1; req0_a = 12'h111; req1_a = 12'h222; rsp_ready = 1;
    do_reset("reset_with_valid");
    for (int i = 0; i < 4; i++) begin
      wait_grant("t3", gid);
      check($sformatf("t3_order%0d", i), 64'(gid), 64'(i % 2));
    end
    @(posedge clk); #1;
    req0_valid = 0;
    wait_grant("t3_solo", gid);
    check("t3_solo_req1", 64'(gid), 64'd1);
    @(posedge clk); #1;
    req1_valid = 0;

    // 4: response back-pressure with req1 pending.
    clear_inputs();
    do_reset("reset_t4");
    req0_a = 12'h123; req0_b = 12'h456; req0_cin = 0; req0_valid = 1;
    wait_grant("t4", gid);
    check("t4_grant0", 64'(gid), 64'd0);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_a = 12'hABC; req1_b = 12'h544; req1_cin = 1; req1_valid = 1;
    wait_rsp("t4", found);
    e = ref_add(12'h123, 12'h456, 1'b0);
    cap = {rsp_sum, rsp_cout, rsp_id};
    check("t4_result", 64'(cap), 64'({e[WIDTH-1:0], e[WIDTH], 1'b0}));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d", i), {rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready},
            64'({1'b1, cap, 2'b00}));
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    check("t4_rsp_hs", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    check("t4_req1_first_idle", {rsp_valid, req0_ready, req1_ready}, 64'b001);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_rsp("t4b", found);
    e = ref_add(12'hABC, 12'h544, 1'b1);
    check("t4b_result", {rsp_sum, rsp_cout, rsp_id}, 64'({e[WIDTH-1:0], e[WIDTH], 1'b1}));

    // 5: reset asserted mid-operation.
    clear_inputs();
    do_reset("reset_t5");
    rsp_ready = 1;
    req0_a = 12'h5A3; req0_b = 12'h0F0; req0_cin = 1; req0_valid = 1;
    wait_grant("t5", gid);
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (3) @(negedge clk);
    check("t5_at_idx2", 64'(slc_a), 64'(SLICE_W'(12'h5A3 >> (2 * SLICE_W))));
    #2;
    rst_n = 0;
    #1;
    check_zero("t5_async_zero");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    nrv = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) nrv++;
    end
    check("t5_no_rsp", 64'(nrv), 64'd0);
    single_op("t5_after", 1, 12'h9C4, 12'h63B, 1'b0);

    // 6: randomized traffic against a transaction-level model.
    begin
      exp_t   q[$];
      exp_t   x;
      logic   pend0 = 0, pend1 = 0, busy = 0, m_last = 1, prev_hold = 0;
      logic [WIDTH+1:0] prev_vals = '0;
      int     issued = 0, done = 0, resp_due = 0, guard = 0;
      logic   exp_r0, exp_r1;
      clear_inputs();
      do_reset("reset_rand");
      while (done < N_RAND && guard < 60000) begin
        @(posedge clk); #1;
        guard++;
        if (!pend0 && issued < N_RAND && $urandom_range(3) != 0) begin
          req0_a = WIDTH'($urandom()); req0_b = WIDTH'($urandom()); req0_cin = 1'($urandom());
          pend0 = 1; issued++;
        end
        if (!pend1 && issued < N_RAND && $urandom_range(3) != 0) begin
          req1_a = WIDTH'($urandom()); req1_b = WIDTH'($urandom()); req1_cin = 1'($urandom());
          pend1 = 1; issued++;
        end
        req0_valid = pend0;
        req1_valid = pend1;
        rsp_ready  = ($urandom_range(2) != 0);
        @(negedge clk);
        exp_r0 = !busy && req0_valid && (!req1_valid || m_last);
        exp_r1 = !busy && req1_valid && (!req0_valid || !m_last);
        check("rand_ready", {req0_ready, req1_ready}, 64'({exp_r0, exp_r1}));
        check("rand_rsp_valid", 64'(rsp_valid), 64'(busy && cyc >= resp_due));
        if (prev_hold) check("rand_stable", {rsp_sum, rsp_cout, rsp_id}, 64'(prev_vals));
        prev_hold = rsp_valid && !rsp_ready;
        prev_vals = {rsp_sum, rsp_cout, rsp_id};
        if (rsp_valid && rsp_ready) begin
          done++;
          busy = 0;
          if (q.size() == 0) begin
            check("rand_unexpected_rsp", 64'd1, 64'd0);
          end else begin
            x = q.pop_front();
            check("rand_result", {rsp_sum, rsp_cout, rsp_id}, 64'({x.val[WIDTH-1:0], x.val[WIDTH], x.id}));
          end
        end
        if (req0_valid && req0_ready) begin
          x.id = 0; x.val = ref_add(req0_a, req0_b, req0_cin); q.push_back(x);
          pend0 = 0; busy = 1; resp_due = cyc + NSLICE + 1; m_last = 0;
        end else if (req1_valid && req1_ready) begin
          x.id = 1; x.val = ref_add(req1_a, req1_b, req1_cin); q.push_back(x);
          pend1 = 0; busy = 1; resp_due = cyc + NSLICE + 1; m_last = 1;
        end
      end
      check("rand_done_count", 64'(done), 64'(N_RAND));
      check("rand_queue_empty", 64'(q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
